// File: rtl/pipeline_stage4_mem.sv
// Memory-access stage of the 16-bit pipelined CPU: bypass or load/store over a req/ack port, then MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT cycles.
module pipeline_stage4_mem #(
    parameter int DATA_W  = 16,
    parameter int WA_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_bypass_in,
    input  logic              mem_we_in,
    input  logic              aux_in,
    input  logic [WA_W-1:0]   wa_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid_out,
    output logic              wb_we_out,
    output logic [WA_W-1:0]   wb_wa_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              err_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              bypass_ret;
    logic              mem_done;
    logic              timeout_hit;
    logic              aux_p1;
    logic [WA_W-1:0]   wa_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in && !mem_bypass_in) state_nxt = ACCESS;
            ACCESS:  if (dmem_ack || timeout_hit)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack is only honoured in ACCESS, where dmem_req is known to be high.
    always_comb begin
        accept     = 1'b0;
        bypass_ret = 1'b0;
        mem_done   = 1'b0;
        stall_out  = 1'b0;
        case (state)
            IDLE: begin
                bypass_ret = valid_in && mem_bypass_in;
                accept     = valid_in && !mem_bypass_in;
                stall_out  = accept;
            end
            ACCESS: begin
                mem_done  = dmem_ack;
                stall_out = !dmem_ack && !timeout_hit;
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_p1;

    assign timeout_hit = (state == ACCESS) && !dmem_ack &&
                         (tmo_cnt_p1 == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_p1 <= '0;
            err_out    <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt_p1 <= '0;
            end else if (state == ACCESS && !dmem_ack) begin
                tmo_cnt_p1 <= tmo_cnt_p1 + 1'b1;
            end
            if (timeout_hit) begin
                err_out <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign err_out        = 1'b0;
`endif

    // Stage boundary: request registers double as the latched address, data and direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            aux_p1     <= 1'b0;
            wa_p1      <= '0;
        end else if (accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_we_in;
            dmem_addr  <= alu_result_in;
            dmem_wdata <= store_data_in;
            aux_p1     <= aux_in;
            wa_p1      <= wa_in;
        end else if (mem_done || timeout_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
        end
    end

    // Stage boundary: MEM/WB register; data and address hold between retirements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_out <= 1'b0;
            wb_we_out    <= 1'b0;
            wb_wa_out    <= '0;
            wb_data_out  <= '0;
        end else begin
            wb_valid_out <= bypass_ret || mem_done || timeout_hit;
            wb_we_out    <= 1'b0;
            if (bypass_ret) begin
                wb_data_out <= alu_result_in;
                wb_wa_out   <= wa_in;
                wb_we_out   <= aux_in;
            end else if (mem_done) begin
                wb_data_out <= dmem_we ? dmem_addr : dmem_rdata;
                wb_wa_out   <= wa_p1;
                wb_we_out   <= !dmem_we && aux_p1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage4_mem.sv
// Scoreboard bench for pipeline_stage4_mem: randomized ops, memory responder and writeback monitor.
module tb_pipeline_stage4_mem;
    localparam int DATA_W     = 16;
    localparam int WA_W       = 5;
    localparam int TB_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              mem_bypass_in;
    logic              mem_we_in;
    logic              aux_in;
    logic [WA_W-1:0]   wa_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] store_data_in;
    logic              stall_out;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              dmem_ack = 1'b0;
    logic              wb_valid_out;
    logic              wb_we_out;
    logic [WA_W-1:0]   wb_wa_out;
    logic [DATA_W-1:0] wb_data_out;
    logic              err_out;

    always #5 clk = ~clk;

    pipeline_stage4_mem #(.DATA_W(DATA_W), .WA_W(WA_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_bypass_in(mem_bypass_in),
        .mem_we_in(mem_we_in), .aux_in(aux_in), .wa_in(wa_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid_out(wb_valid_out), .wb_we_out(wb_we_out),
        .wb_wa_out(wb_wa_out), .wb_data_out(wb_data_out), .err_out(err_out)
    );

    typedef struct {
        logic              we;
        logic [WA_W-1:0]   wa;
        logic [DATA_W-1:0] data;
        bit                dc;
    } wb_exp_t;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];
    wb_exp_t  wb_e;
    mem_exp_t mem_e;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents as a fixed function of address.
    function automatic logic [DATA_W-1:0] mem_f(input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = a * 16'd40503;
        return p ^ 16'h9E37;
    endfunction

    // Memory responder: acks after next_lat idle cycles, spurious acks while idle.
    int                next_lat = 0;
    bit                in_txn = 1'b0;
    int                wait_left = 0;
    logic              cur_we;
    logic [DATA_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            in_txn   = 1'b0;
            dmem_ack = 1'b0;
        end else if (!dmem_req) begin
            in_txn     = 1'b0;
            dmem_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = 16'($urandom);
        end else begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                wait_left = next_lat;
                cur_we    = dmem_we;
                cur_addr  = dmem_addr;
                cur_wdata = dmem_wdata;
                if (mem_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_req: unexpected request addr 0x%0h", dmem_addr);
                end else begin
                    mem_e = mem_q.pop_front();
                    check("mem_we", 32'(dmem_we), 32'(mem_e.we));
                    check("mem_addr", 32'(dmem_addr), 32'(mem_e.addr));
                    check("mem_wdata", 32'(dmem_wdata), 32'(mem_e.wdata));
                end
            end else begin
                check("mem_we_stable", 32'(dmem_we), 32'(cur_we));
                check("mem_addr_stable", 32'(dmem_addr), 32'(cur_addr));
                check("mem_wdata_stable", 32'(dmem_wdata), 32'(cur_wdata));
            end
            if (wait_left == 0) begin
                dmem_ack   = 1'b1;
                dmem_rdata = mem_f(dmem_addr);
                in_txn     = 1'b0;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = 16'($urandom);
                wait_left--;
            end
        end
    end

    // Writeback monitor.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (wb_valid_out) begin
                if (wb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_retire: unexpected retirement wa=%0d data=0x%0h", wb_wa_out, wb_data_out);
                end else begin
                    wb_e = wb_q.pop_front();
                    check("wb_we", 32'(wb_we_out), 32'(wb_e.we));
                    if (!wb_e.dc) begin
                        check("wb_wa", 32'(wb_wa_out), 32'(wb_e.wa));
                        check("wb_data", 32'(wb_data_out), 32'(wb_e.data));
                    end
                end
            end else begin
                check("wb_we_idle", 32'(wb_we_out), 32'd0);
            end
        end
    end

    // kind: 0 bubble, 1 bypass, 2 load, 3 store, 4 load that is never acknowledged.
    task automatic issue(input int kind, input logic aux, input logic [WA_W-1:0] wa,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                         input int lat, output int stalls);
        int cyc;
        bit st;
        next_lat      = lat;
        valid_in      = (kind != 0);
        mem_bypass_in = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom) : 1'b0;
        mem_we_in     = (kind == 3) ? 1'b1 : (kind == 1 || kind == 0) ? 1'($urandom) : 1'b0;
        aux_in        = aux;
        wa_in         = wa;
        alu_result_in = alu;
        store_data_in = sd;
        case (kind)
            1: wb_q.push_back('{aux, wa, alu, 1'b0});
            2: begin
                mem_q.push_back('{1'b0, alu, sd});
                wb_q.push_back('{aux, wa, mem_f(alu), 1'b0});
            end
            3: begin
                mem_q.push_back('{1'b1, alu, sd});
                wb_q.push_back('{1'b0, wa, alu, 1'b0});
            end
            4: begin
                mem_q.push_back('{1'b0, alu, sd});
                wb_q.push_back('{1'b0, wa, alu, 1'b1});
            end
            default: ;
        endcase
        stalls = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            #2;
            st = stall_out;
            if (st) stalls++;
            @(posedge clk);
            #1;
            if (!st) break;
            cyc++;
            if (cyc > 1000) begin
                n_cmp++;
                n_err++;
                $display("FAIL stall_bound: stall_out stuck high for %0d cycles, expected release", cyc);
                break;
            end
        end
        valid_in = 1'b0;
        check("wb_valid_timing", 32'(wb_valid_out), (kind != 0) ? 32'd1 : 32'd0);
        if (kind >= 2) check("req_single", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        int s;
        int kind;
        int lat;
        rst           = 1'b0;
        valid_in      = 1'b0;
        mem_bypass_in = 1'b0;
        mem_we_in     = 1'b0;
        aux_in        = 1'b0;
        wa_in         = '0;
        alu_result_in = '0;
        store_data_in = '0;
        #12;
        check("rst_wb_valid", 32'(wb_valid_out), 32'd0);
        check("rst_wb_we", 32'(wb_we_out), 32'd0);
        check("rst_wb_wa", 32'(wb_wa_out), 32'd0);
        check("rst_wb_data", 32'(wb_data_out), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 1'b1, 5'd5, 16'h1234, 16'h0000, 0, s);
        check("bypass_stall_cycles", 32'(s), 32'd0);
        check("bypass_wb_data", 32'(wb_data_out), 32'h1234);
        issue(2, 1'b1, 5'd3, 16'h0040, 16'h0000, 3, s);
        check("load_stall_cycles", 32'(s), 32'd4);
        check("load_wb_data", 32'(wb_data_out), 32'(mem_f(16'h0040)));
        issue(3, 1'b1, 5'd7, 16'h0010, 16'hA5A5, 0, s);
        check("store_stall_cycles", 32'(s), 32'd1);
        check("store_wb_data", 32'(wb_data_out), 32'h0010);
        for (int i = 0; i < 3; i++) begin
            issue(0, 1'b1, 5'd1, 16'hFFFF, 16'h0000, 0, s);
            check("bubble_stall", 32'(s), 32'd0);
            check("bubble_req", 32'(dmem_req), 32'd0);
        end

`ifdef MEM_TIMEOUT_EN
        issue(4, 1'b1, 5'd9, 16'h0200, 16'h0000, 100000, s);
        check("timeout_stall_cycles", 32'(s), 32'(TB_TIMEOUT));
        check("timeout_err", 32'(err_out), 32'd1);
        issue(1, 1'b1, 5'd2, 16'h0777, 16'h0000, 0, s);
        check("timeout_err_sticky", 32'(err_out), 32'd1);
`endif

        // Reset asserted while a load is outstanding.
        next_lat      = 100000;
        valid_in      = 1'b1;
        mem_bypass_in = 1'b0;
        mem_we_in     = 1'b0;
        aux_in        = 1'b1;
        wa_in         = 5'd4;
        alu_result_in = 16'h0080;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("midrst_req_before", 32'(dmem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_addr", 32'(dmem_addr), 32'd0);
        check("midrst_wb_data", 32'(wb_data_out), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid_out), 32'd0);
        check("midrst_err", 32'(err_out), 32'd0);
        check("midrst_stall", 32'(stall_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 1'b0, 5'd6, 16'h4321, 16'h0000, 0, s);
        check("post_rst_bypass_stall", 32'(s), 32'd0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            lat  = $urandom_range(0, TB_TIMEOUT - 1);
            issue(kind, 1'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), lat, s);
            check("rand_stall_cycles", 32'(s), (kind >= 2) ? 32'(1 + lat) : 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
`ifndef MEM_TIMEOUT_EN
        check("err_tied_low", 32'(err_out), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
